// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline stages and the central stall/flush controller.
// The pipeline side is the master (drives hazard status); the controller is the slave.
interface pipeline_hazard_ctrl_if #(
  parameter int WIDTH_REG = 5,
  parameter int CNT_W     = 16
);
  logic [WIDTH_REG-1:0] id_rs1;
  logic [WIDTH_REG-1:0] id_rs2;
  logic                 id_use_rs1;
  logic                 id_use_rs2;
  logic                 ex_valid;
  logic                 ex_mem_read;
  logic [WIDTH_REG-1:0] ex_rd;
  logic                 ex_branch_taken;
  logic                 ex_multi_start;
  logic                 dmem_req;
  logic                 dmem_ready;

  logic                 stop_IF;
  logic                 stop_ID;
  logic                 stop_EX;
  logic                 flush_IF_ID;
  logic                 flush_ID_EX;
  logic                 flush_MEM_WB;
  logic                 busy_multi;
  logic [CNT_W-1:0]     stall_cycles;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_valid, ex_mem_read, ex_rd, ex_branch_taken, ex_multi_start,
    output dmem_req, dmem_ready,
    input  stop_IF, stop_ID, stop_EX,
    input  flush_IF_ID, flush_ID_EX, flush_MEM_WB,
    input  busy_multi, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_valid, ex_mem_read, ex_rd, ex_branch_taken, ex_multi_start,
    input  dmem_req, dmem_ready,
    output stop_IF, stop_ID, stop_EX,
    output flush_IF_ID, flush_ID_EX, flush_MEM_WB,
    output busy_multi, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: resolves memory waits, iterative
// EX ops, taken branches and load-use hazards by priority, and counts front-end stall cycles.
module pipeline_hazard_ctrl #(
  parameter int WIDTH_REG    = 5,
  parameter int MULTI_CYCLES = 8,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  // cnt holds the stall cycles still owed after the first one; it must fit MULTI_CYCLES-2.
  localparam int CW = (MULTI_CYCLES > 2) ? $clog2(MULTI_CYCLES - 1) : 1;

  typedef enum logic {
    ST_RUN,
    ST_MULTI
  } state_t;

  typedef struct packed {
    logic stop_if;
    logic stop_id;
    logic stop_ex;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_mem_wb;
  } ctl_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [CNT_W-1:0] r_stall_cycles;

  state_t           w_next_state;
  logic [CW-1:0]    w_next_cnt;
  ctl_t             w_ctl;
  logic             w_mem_stall;
  logic             w_rs1_hit;
  logic             w_rs2_hit;
  logic             w_load_use;

  assign w_mem_stall = hz.dmem_req & ~hz.dmem_ready;
  assign w_rs1_hit   = hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd);
  assign w_rs2_hit   = hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd);
  assign w_load_use  = hz.ex_valid & hz.ex_mem_read & (hz.ex_rd != '0) & (w_rs1_hit | w_rs2_hit);

  // Control acts in the same cycle as its cause; the rst_n term keeps every control output
  // low for the whole reset window, not just after the next edge.
  always_comb begin
    // NOTE: every signal gets a default before the priority chain so no path infers a latch.
    w_ctl        = '0;
    w_next_state = r_state;
    w_next_cnt   = r_cnt;

    if (w_mem_stall) begin
      w_ctl.stop_if      = 1'b1;
      w_ctl.stop_id      = 1'b1;
      w_ctl.stop_ex      = 1'b1;
      w_ctl.flush_mem_wb = 1'b1;
    end else if (r_state == ST_MULTI) begin
      if (r_cnt != '0) begin
        w_ctl.stop_if = 1'b1;
        w_ctl.stop_id = 1'b1;
        w_ctl.stop_ex = 1'b1;
        w_next_cnt    = r_cnt - CW'(1);
      end else begin
        w_next_state  = ST_RUN;
      end
    end else if (hz.ex_branch_taken) begin
      w_ctl.flush_if_id = 1'b1;
      w_ctl.flush_id_ex = 1'b1;
    end else if (hz.ex_multi_start) begin
      w_ctl.stop_if = 1'b1;
      w_ctl.stop_id = 1'b1;
      w_ctl.stop_ex = 1'b1;
      w_next_cnt    = CW'(MULTI_CYCLES - 2);
      w_next_state  = ST_MULTI;
    end else if (w_load_use) begin
      // One bubble is enough: next cycle the load has moved to MEM and can forward.
      w_ctl.stop_if     = 1'b1;
      w_ctl.flush_id_ex = 1'b1;
    end

    if (!rst_n) begin
      w_ctl = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_RUN;
      r_cnt          <= '0;
      r_stall_cycles <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers sample together.
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_ctl.stop_if && (r_stall_cycles != {CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
    end
  end

  assign hz.stop_IF      = w_ctl.stop_if;
  assign hz.stop_ID      = w_ctl.stop_id;
  assign hz.stop_EX      = w_ctl.stop_ex;
  assign hz.flush_IF_ID  = w_ctl.flush_if_id;
  assign hz.flush_ID_EX  = w_ctl.flush_id_ex;
  assign hz.flush_MEM_WB = w_ctl.flush_mem_wb;
  assign hz.busy_multi   = (r_state == ST_MULTI);
  assign hz.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: two controller instances (default sizing, and MULTI_CYCLES=2/CNT_W=4)
// driven with identical directed and random stimulus, compared against a cycle-level model.
module tb_pipeline_hazard_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.WIDTH_REG(5), .CNT_W(16)) hz0 ();
  pipeline_hazard_ctrl_if #(.WIDTH_REG(5), .CNT_W(4))  hz1 ();

  pipeline_hazard_ctrl #(.WIDTH_REG(5), .MULTI_CYCLES(8), .CNT_W(16)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz0.slave)
  );

  pipeline_hazard_ctrl #(.WIDTH_REG(5), .MULTI_CYCLES(2), .CNT_W(4)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz1.slave)
  );

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic       ex_valid;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic       br;
    logic       start;
    logic       req;
    logic       rdy;
  } stim_t;

  int n_checks = 0;
  int n_pass   = 0;
  int n_cycle  = 0;

  // Model state: cycles of the multi-cycle op still to run (including the release cycle),
  // and the expected stall counter.
  int left0 = 0, cnt0 = 0;
  int left1 = 0, cnt1 = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, n_cycle, act, exp);
  endtask

  task automatic apply(input stim_t s);
    hz0.id_rs1 = s.rs1;            hz1.id_rs1 = s.rs1;
    hz0.id_rs2 = s.rs2;            hz1.id_rs2 = s.rs2;
    hz0.id_use_rs1 = s.use1;       hz1.id_use_rs1 = s.use1;
    hz0.id_use_rs2 = s.use2;       hz1.id_use_rs2 = s.use2;
    hz0.ex_valid = s.ex_valid;     hz1.ex_valid = s.ex_valid;
    hz0.ex_mem_read = s.ex_mem_read; hz1.ex_mem_read = s.ex_mem_read;
    hz0.ex_rd = s.ex_rd;           hz1.ex_rd = s.ex_rd;
    hz0.ex_branch_taken = s.br;    hz1.ex_branch_taken = s.br;
    hz0.ex_multi_start = s.start;  hz1.ex_multi_start = s.start;
    hz0.dmem_req = s.req;          hz1.dmem_req = s.req;
    hz0.dmem_ready = s.rdy;        hz1.dmem_ready = s.rdy;
  endtask

  // Expected control vector {stop_IF, stop_ID, stop_EX, flush_IF_ID, flush_ID_EX, flush_MEM_WB,
  // busy_multi} and next model state, straight from the priority table.
  function automatic void model(input stim_t s, input int mc, input int cmax,
                                input int left_in, input int cnt_in,
                                output logic [6:0] ctl, output int left_out, output int cnt_out);
    bit ms, lu, s_if, s_id, s_ex, f_ifid, f_idex, f_mw;
    ms = s.req && !s.rdy;
    lu = s.ex_valid && s.ex_mem_read && (s.ex_rd != 0) &&
         ((s.use1 && s.rs1 == s.ex_rd) || (s.use2 && s.rs2 == s.ex_rd));
    {s_if, s_id, s_ex, f_ifid, f_idex, f_mw} = '0;
    left_out = left_in;
    if (ms) begin
      {s_if, s_id, s_ex, f_mw} = 4'b1111;
    end else if (left_in > 0) begin
      if (left_in > 1) {s_if, s_id, s_ex} = 3'b111;
      left_out = left_in - 1;
    end else if (s.br) begin
      {f_ifid, f_idex} = 2'b11;
    end else if (s.start) begin
      {s_if, s_id, s_ex} = 3'b111;
      left_out = mc - 1;
    end else if (lu) begin
      {s_if, f_idex} = 2'b11;
    end
    ctl = {s_if, s_id, s_ex, f_ifid, f_idex, f_mw, left_in > 0};
    cnt_out = (s_if && cnt_in < cmax) ? cnt_in + 1 : cnt_in;
  endfunction

  function automatic logic [6:0] obs0();
    return {hz0.stop_IF, hz0.stop_ID, hz0.stop_EX, hz0.flush_IF_ID, hz0.flush_ID_EX,
            hz0.flush_MEM_WB, hz0.busy_multi};
  endfunction

  function automatic logic [6:0] obs1();
    return {hz1.stop_IF, hz1.stop_ID, hz1.stop_EX, hz1.flush_IF_ID, hz1.flush_ID_EX,
            hz1.flush_MEM_WB, hz1.busy_multi};
  endfunction

  // Called at a negedge: drive, check combinational outputs, then advance one clock.
  task automatic cycle(input stim_t s);
    logic [6:0] c0, c1;
    int nl0, nc0, nl1, nc1;
    apply(s);
    #1;
    model(s, 8, 65535, left0, cnt0, c0, nl0, nc0);
    model(s, 2, 15, left1, cnt1, c1, nl1, nc1);
    check("ctl0", 32'(obs0()), 32'(c0));
    check("stall_cycles0", 32'(hz0.stall_cycles), 32'(cnt0));
    check("ctl1", 32'(obs1()), 32'(c1));
    check("stall_cycles1", 32'(hz1.stall_cycles), 32'(cnt1));
    @(posedge clk);
    left0 = nl0; cnt0 = nc0;
    left1 = nl1; cnt1 = nc1;
    n_cycle++;
    @(negedge clk);
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, "_ctl0"}, 32'(obs0()), 32'd0);
    check({tag, "_cnt0"}, 32'(hz0.stall_cycles), 32'd0);
    check({tag, "_ctl1"}, 32'(obs1()), 32'd0);
    check({tag, "_cnt1"}, 32'(hz1.stall_cycles), 32'd0);
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.rs1         = 5'($urandom_range(0, 3));
    s.rs2         = 5'($urandom_range(0, 3));
    s.use1        = 1'($urandom_range(0, 1));
    s.use2        = 1'($urandom_range(0, 1));
    s.ex_valid    = ($urandom_range(0, 3) != 0);
    s.ex_mem_read = 1'($urandom_range(0, 1));
    s.ex_rd       = 5'($urandom_range(0, 3));
    s.br          = ($urandom_range(0, 5) == 0);
    s.start       = ($urandom_range(0, 7) == 0);
    s.req         = ($urandom_range(0, 3) == 0);
    s.rdy         = 1'($urandom_range(0, 1));
    return s;
  endfunction

  initial begin
    stim_t s, lu_s;

    // Reset window: outputs stay low even with hazards present on the inputs.
    apply(stim_t'(0));
    repeat (2) begin
      @(negedge clk);
      s = rand_stim();
      s.req = 1'b1; s.rdy = 1'b0;
      apply(s);
      #1;
      check_reset_zero("reset");
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use on rs2, then the same with x0 as destination.
    lu_s = '0;
    lu_s.ex_valid = 1'b1; lu_s.ex_mem_read = 1'b1; lu_s.ex_rd = 5'd5;
    lu_s.rs2 = 5'd5; lu_s.use2 = 1'b1;
    cycle(lu_s);
    cycle(stim_t'(0));
    s = lu_s; s.ex_rd = 5'd0; s.rs2 = 5'd0;
    cycle(s);

    // Branch wins over load-use; dmem_ready without a request is harmless.
    s = lu_s; s.br = 1'b1;
    cycle(s);
    s = lu_s; s.rdy = 1'b1;
    cycle(s);

    // Multi-cycle op held for 8 cycles, then idle.
    s = '0; s.start = 1'b1;
    repeat (8) cycle(s);
    repeat (2) cycle(stim_t'(0));

    // Memory wait of 3 cycles arriving in cycle 3 of a multi-cycle op.
    s = '0; s.start = 1'b1;
    repeat (2) cycle(s);
    s.req = 1'b1;
    repeat (3) cycle(s);
    s.req = 1'b0;
    repeat (6) cycle(s);
    repeat (2) cycle(stim_t'(0));

    // Long memory wait: the 4-bit counter saturates at 15.
    s = '0; s.req = 1'b1;
    repeat (20) cycle(s);
    cycle(stim_t'(0));

    // Asynchronous reset dropped between edges in the middle of a multi-cycle op.
    s = '0; s.start = 1'b1;
    repeat (3) cycle(s);
    s.req = 1'b1;
    apply(s);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_zero("async_reset");
    left0 = 0; cnt0 = 0; left1 = 0; cnt1 = 0;
    @(negedge clk);
    check_reset_zero("async_hold");
    rst_n = 1'b1;
    cycle(stim_t'(0));
    cycle(lu_s);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      cycle(rand_stim());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
